// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the data/fetch RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_D = 3'd1,
    BUSY_I = 3'd2,
    RESP_D = 3'd3,
    RESP_I = 3'd4
  } arb_state_e;

  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_BYTE = 2'b01;
  localparam logic [1:0] RD_WORD = 2'b10;
  localparam logic [1:0] RD_RSV  = 2'b11;

  // Wide enough for RAM_LAT and STARVE_MAX up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable counter with a terminal flag: down-count to zero, or saturating
// up-count to LIMIT with the load acting as a clear.
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter bit               UP_MODE = 1'b0,
  parameter logic [CNT_W-1:0] LIMIT   = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_flag
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= UP_MODE ? '0 : LIMIT;
    end else if (i_en) begin
      if (UP_MODE) begin
        if (r_cnt != LIMIT) r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_flag = UP_MODE ? (r_cnt == LIMIT) : (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port RAM between the MEM-stage load/store port and
// instruction fetch; data has priority, fetch wins after STARVE_MAX denials.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RAM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_read,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_quarter,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic [1:0]        d_quarter_out,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_mem,
  output logic              stall_if,
  output logic              err_conflict
);

  arb_state_e        r_state, w_state_nxt;
  logic              w_d_rd, w_d_req;
  logic              w_gnt_i, w_gnt_d_rd, w_gnt_d_wr;
  logic              w_lat_zero, w_starve_max, w_busy;
  logic              w_d_done, w_i_done;
  logic [1:0]        r_tag;
  logic              r_byte, r_hi;
  logic [DATA_W-1:0] r_d_rdata, r_i_rdata;
  logic [1:0]        r_d_qtr;
  logic              r_d_rvalid, r_i_rvalid, r_err;

  assign w_d_rd   = (d_read != RD_NONE);
  assign w_d_req  = w_d_rd | d_write;
  assign w_busy   = (r_state == BUSY_D) | (r_state == BUSY_I);
  assign w_d_done = (r_state == BUSY_D) & w_lat_zero;
  assign w_i_done = (r_state == BUSY_I) & w_lat_zero;

  mem_arb_lat_cnt #(
    .UP_MODE (1'b0),
    .LIMIT   (CNT_W'(RAM_LAT - 1))
  ) u_lat_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_gnt_i | w_gnt_d_rd),
    .i_en   (w_busy),
    .o_flag (w_lat_zero)
  );

  mem_arb_lat_cnt #(
    .UP_MODE (1'b1),
    .LIMIT   (CNT_W'(STARVE_MAX))
  ) u_starve_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_gnt_i | ~i_req),
    .i_en   (i_req & ~w_gnt_i),
    .o_flag (w_starve_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Grants and next state; a response cycle only serves the other requester.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_i     = 1'b0;
    w_gnt_d_rd  = 1'b0;
    w_gnt_d_wr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req && (!w_d_req || w_starve_max)) w_gnt_i    = 1'b1;
        else if (d_write)                        w_gnt_d_wr = 1'b1;
        else if (w_d_rd)                         w_gnt_d_rd = 1'b1;
      end
      BUSY_D: if (w_lat_zero) w_state_nxt = RESP_D;
      BUSY_I: if (w_lat_zero) w_state_nxt = RESP_I;
      RESP_D: begin
        w_state_nxt = IDLE;
        w_gnt_i     = i_req;
      end
      RESP_I: begin
        w_state_nxt = IDLE;
        if (d_write)     w_gnt_d_wr = 1'b1;
        else if (w_d_rd) w_gnt_d_rd = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_gnt_i)    w_state_nxt = BUSY_I;
    if (w_gnt_d_rd) w_state_nxt = BUSY_D;
  end

  // RAM command and stalls, forced low while in reset.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_re    = rst_n & (w_gnt_i | w_gnt_d_rd);
    ram_we    = rst_n & w_gnt_d_wr;
    stall_mem = rst_n & w_d_req & ~w_gnt_d_wr & ~r_d_rvalid;
    stall_if  = rst_n & i_req & ~r_i_rvalid;
    if (rst_n) begin
      if (w_gnt_i)                      ram_addr = i_addr;
      else if (w_gnt_d_rd | w_gnt_d_wr) ram_addr = d_addr;
      if (w_gnt_d_wr)                   ram_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag      <= '0;
      r_byte     <= 1'b0;
      r_hi       <= 1'b0;
      r_d_rdata  <= '0;
      r_i_rdata  <= '0;
      r_d_qtr    <= '0;
      r_d_rvalid <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_d_rvalid <= w_d_done;
      r_i_rvalid <= w_i_done;
      r_err      <= r_err | (w_d_rd & d_write);
      if (w_gnt_d_rd) begin
        r_tag  <= d_quarter;
        r_byte <= (d_read == RD_BYTE);
        r_hi   <= d_addr[0];
      end
      if (w_d_done) begin
        r_d_qtr <= r_tag;
        if (!r_byte)  r_d_rdata <= ram_rdata;
        else if (r_hi) r_d_rdata <= DATA_W'(ram_rdata[15:8]);
        else           r_d_rdata <= DATA_W'(ram_rdata[7:0]);
      end
      if (w_i_done) r_i_rdata <= ram_rdata;
    end
  end

  assign d_rdata       = r_d_rdata;
  assign d_rvalid      = r_d_rvalid;
  assign d_quarter_out = r_d_qtr;
  assign i_rdata       = r_i_rdata;
  assign i_rvalid      = r_i_rvalid;
  assign err_conflict  = r_err;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port data/instruction RAM between the MEM-stage load/store port, fed by the EX/MEM latch, and the instruction-fetch port. It sequences RAM commands with a fixed read latency and returns read data with the register-quarter tag. It stalls whichever pipeline stage is waiting, and gives data accesses priority with a bounded starvation guard for fetch.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- RAM_LAT, 2, cycles from read command to valid ram_rdata (legal range 1..15)
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch wins (legal range 1..15)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- d_addr  in  ADDR_W  data address from EX/MEM
- d_read  in  2  ReadMem: 00 none, 01 byte, 10 word, 11 treated as word
- d_write  in  1  WriteMem
- d_wdata  in  DATA_W  store data
- d_quarter  in  2  destination quarter tag, returned with read data
- d_rdata  out  DATA_W  load data; byte reads zero-extended, d_addr[0]=0 selects low byte
- d_rvalid  out  1  one-cycle load-complete pulse
- d_quarter_out  out  2  tag captured at grant, valid with d_rvalid
- i_req, i_addr  in  1, ADDR_W  fetch request (level) and address
- i_rdata, i_rvalid  out  DATA_W, 1  fetch word and one-cycle pulse
- ram_addr, ram_wdata  out  ADDR_W, DATA_W  RAM command
- ram_re, ram_we  out  1, 1  RAM strobes, at most one high per cycle
- ram_rdata  in  DATA_W  RAM read data
- stall_mem, stall_if  out  1, 1  hold EX/MEM latch / hold fetch stage
- err_conflict  out  1  sticky: d_read≠00 and d_write seen together

## Operation
- Data request present when d_read≠00 or d_write=1; fetch request present when i_req=1.
- States:
  - IDLE: arbitrates.
  - BUSY_D, BUSY_I: RAM_LAT cycles of read wait; no grants.
  - RESP_D, RESP_I: response cycle; only the other requester may be granted.
- Arbitration in IDLE: data wins unless the starve counter equals STARVE_MAX, in which case fetch wins.
  - Starve counter increments on each cycle fetch is requested but denied.
  - It clears on a fetch grant or when i_req=0.
  - It saturates at STARVE_MAX.
- Data write grant: ram_we=1 for that cycle, stays IDLE, no response. Back-to-back writes are allowed every cycle.
- Read grant: ram_re=1, ram_addr set, tag captured, then → BUSY_x.
  - The latency counter loads RAM_LAT-1 and moves → RESP_x when it reaches 0.
  - ram_rdata is registered into d_rdata/i_rdata entering RESP_x.
- RESP_x → IDLE, or → BUSY_y if the other requester is granted in RESP_x. A write grant in RESP_I stays → IDLE.
- Simultaneous d_read≠00 and d_write: the write is performed, the read is ignored, and err_conflict is set until reset.
- Outputs:
  - stall_mem = data request present, and not (write granted this cycle), and not d_rvalid.
  - stall_if = i_req and not i_rvalid.
- Reset (any time, including mid-read): state → IDLE, counters 0, the pending read is dropped with no rvalid, and err_conflict is cleared.
- While rst_n=0, all outputs are forced to 0, including the combinational ram_* and stall_* outputs.

## Timing
- Read granted in cycle T:
  - ram_re=1 in T.
  - ram_rdata is sampled in T+RAM_LAT.
  - d_rvalid/i_rvalid=1 in T+RAM_LAT+1.
  - stall high in T..T+RAM_LAT.
- Read throughput from one requester: one per RAM_LAT+2 cycles. The response cycle blocks re-grant of the still-held request.
- Write: zero added latency; stall_mem=0 in the grant cycle.
- d_rdata, i_rdata and d_quarter_out hold their value until the next response of their port.
- Reset values: all outputs 0.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY_D, BUSY_I, RESP_D, RESP_I);
  - ReadMem encodings RD_NONE=2'b00, RD_BYTE=2'b01, RD_WORD=2'b10, RD_RSV=2'b11.
- One sub-module, mem_arb_lat_cnt: a loadable down-counter with a zero flag. It is reused for latency, and for starvation as a saturating up-count variant via a mode parameter.

## Test plan
- Word read, RAM_LAT=2:
  - Stimulus: d_read=10, d_addr=0x0040, d_quarter=2, ram_rdata=0xBEEF at T+2.
  - Response: ram_re in T, stall_mem in T..T+2, d_rvalid in T+3 with d_rdata=0xBEEF and d_quarter_out=2.
- Byte read:
  - Stimulus: d_read=01, d_addr=0x0041, ram_rdata=0x12AB.
  - Response: d_rdata=0x0012.
- Three consecutive writes: ram_we=1 on three consecutive cycles, stall_mem=0 throughout.
- Continuous writes with i_req=1, STARVE_MAX=4: fetch is granted on the 5th cycle, and stall_mem=1 in that cycle.
- Contention with RAM_LAT=2, data read and fetch requested together: data granted in T, d_rvalid in T+3, fetch granted in T+3, i_rvalid in T+6.
- Protocol errors:
  - rst_n dropped in T+1 of a read: no d_rvalid, all outputs 0, state IDLE after release.
  - d_read=10 with d_write=1: ram_we=1, no ram_re, err_conflict=1 until reset.
